// File: rtl/mode_router.sv
// mode_router: selects one of NUM_MODES play-mode engines and routes its
// speaker bit and display word to the outputs.
//
// The raw mode switch and the next/prev buttons pass through 2-flop
// synchronizers first. The mode switch is then debounced. A mode change
// inserts a silent MUTE gap of MUTE_CYCLES cycles before the new mode is
// routed. Button rising edges are sent as one-cycle pulses to the active
// engine only.
//
// Optional feature macro: MODE_ROUTER_MUTE_EN
//   defined   : a mode change passes through the MUTE state
//   undefined : an accepted mode is routed on the next cycle and
//               switching stays 0
//
// Ports
//   clk, reset   : system clock, asynchronous active-high reset
//   mode_select  : raw mode switch (SEL_W)
//   next_song    : raw button level
//   prev_song    : raw button level
//   speaker_in   : per-mode speaker bits
//   display_in   : per-mode display words, slice i belongs to mode i
//   speaker      : routed speaker bit, registered
//   song_num     : routed display word, registered
//   mode_active  : one-hot engine enable, all zero while muted
//   next_pulse   : one-cycle pulse to the active mode
//   prev_pulse   : one-cycle pulse to the active mode
//   current_mode : index of the routed mode
//   switching    : high while in MUTE
// SEL_W must equal clog2(NUM_MODES).
module mode_router #(
    parameter int NUM_MODES       = 4,
    parameter int SEL_W           = 2,
    parameter int DISP_W          = 7,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MUTE_CYCLES     = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SEL_W-1:0]            mode_select,
    input  logic                        next_song,
    input  logic                        prev_song,
    input  logic [NUM_MODES-1:0]        speaker_in,
    input  logic [NUM_MODES*DISP_W-1:0] display_in,
    output logic                        speaker,
    output logic [DISP_W-1:0]           song_num,
    output logic [NUM_MODES-1:0]        mode_active,
    output logic [NUM_MODES-1:0]        next_pulse,
    output logic [NUM_MODES-1:0]        prev_pulse,
    output logic [SEL_W-1:0]            current_mode,
    output logic                        switching
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int MC_W = $clog2(MUTE_CYCLES + 1);

    typedef enum logic {ST_ACTIVE = 1'b0, ST_MUTE = 1'b1} state_t;

    logic [SEL_W-1:0]     sel_s1_q, sel_s2_q;
    logic                 nxt_s1_q, nxt_s2_q, nxt_d_q;
    logic                 prv_s1_q, prv_s2_q, prv_d_q;
    logic [SEL_W-1:0]     sel_clean;
    logic [SEL_W-1:0]     cand_q, cand_d, acc_q, acc_d;
    logic [DB_W-1:0]      db_cnt_q, db_cnt_d;
    state_t               state_q, state_d;
    logic [SEL_W-1:0]     cur_q, cur_d, target_q, target_d;
    logic [MC_W-1:0]      mcnt_q, mcnt_d;
    logic                 speaker_q, speaker_d;
    logic [DISP_W-1:0]    song_q, song_d;
    logic [NUM_MODES-1:0] next_pulse_q, next_pulse_d, prev_pulse_q, prev_pulse_d;
    logic [NUM_MODES-1:0] onehot_cur;
    logic                 nxt_rise, prv_rise;

    // Synchronizers, debounce and edge-detect history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_s1_q <= '0;
            sel_s2_q <= '0;
            nxt_s1_q <= 1'b0;
            nxt_s2_q <= 1'b0;
            nxt_d_q  <= 1'b0;
            prv_s1_q <= 1'b0;
            prv_s2_q <= 1'b0;
            prv_d_q  <= 1'b0;
            cand_q   <= '0;
            db_cnt_q <= '0;
            acc_q    <= '0;
        end else begin
            sel_s1_q <= mode_select;
            sel_s2_q <= sel_s1_q;
            nxt_s1_q <= next_song;
            nxt_s2_q <= nxt_s1_q;
            nxt_d_q  <= nxt_s2_q;
            prv_s1_q <= prev_song;
            prv_s2_q <= prv_s1_q;
            prv_d_q  <= prv_s2_q;
            cand_q   <= cand_d;
            db_cnt_q <= db_cnt_d;
            acc_q    <= acc_d;
        end
    end

    // Debounce. db_cnt counts consecutive equal samples, including the
    // current one, and saturates at DEBOUNCE_CYCLES. The candidate is
    // accepted on the edge that takes the DEBOUNCE_CYCLES-th sample.
    always_comb begin
        sel_clean = sel_s2_q;
        if ({1'b0, sel_s2_q} >= (SEL_W+1)'(NUM_MODES)) sel_clean = '0;
        cand_d   = cand_q;
        db_cnt_d = db_cnt_q;
        acc_d    = acc_q;
        if (sel_clean != cand_q) begin
            cand_d   = sel_clean;
            db_cnt_d = DB_W'(1);
        end else if (db_cnt_q < DB_W'(DEBOUNCE_CYCLES)) begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
        if (db_cnt_d == DB_W'(DEBOUNCE_CYCLES)) acc_d = cand_d;
    end

    // FSM state register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_ACTIVE;
            cur_q        <= '0;
            target_q     <= '0;
            mcnt_q       <= '0;
            speaker_q    <= 1'b0;
            song_q       <= '0;
            next_pulse_q <= '0;
            prev_pulse_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            target_q     <= target_d;
            mcnt_q       <= mcnt_d;
            speaker_q    <= speaker_d;
            song_q       <= song_d;
            next_pulse_q <= next_pulse_d;
            prev_pulse_q <= prev_pulse_d;
        end
    end

    // Next state
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        target_d = target_q;
        mcnt_d   = mcnt_q;
`ifdef MODE_ROUTER_MUTE_EN
        case (state_q)
            ST_ACTIVE: begin
                if (acc_q != cur_q) begin
                    state_d  = ST_MUTE;
                    target_d = acc_q;
                    mcnt_d   = MC_W'(MUTE_CYCLES - 1);
                end
            end
            ST_MUTE: begin
                if (acc_q != target_q) begin
                    // A new mode was accepted mid-gap: retarget, or cancel
                    // the gap when the user went back to the current mode.
                    if (acc_q == cur_q) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        target_d = acc_q;
                        mcnt_d   = MC_W'(MUTE_CYCLES - 1);
                    end
                end else if (mcnt_q == '0) begin
                    cur_d   = target_q;
                    state_d = ST_ACTIVE;
                end else begin
                    mcnt_d = mcnt_q - 1'b1;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
`else
        cur_d   = acc_q;
        state_d = ST_ACTIVE;
`endif
    end

    // Outputs. Speaker and display use next-state values, so they go
    // silent on the same edge that MUTE is entered.
    always_comb begin
        onehot_cur         = '0;
        onehot_cur[cur_q]  = 1'b1;
        mode_active        = (state_q == ST_ACTIVE) ? onehot_cur : '0;
        switching          = (state_q == ST_MUTE);
        speaker_d          = 1'b0;
        song_d             = '0;
        if (state_d == ST_ACTIVE) begin
            speaker_d = speaker_in[cur_d];
            song_d    = display_in[cur_d*DISP_W +: DISP_W];
        end
        nxt_rise     = nxt_s2_q & ~nxt_d_q;
        prv_rise     = prv_s2_q & ~prv_d_q;
        next_pulse_d = '0;
        prev_pulse_d = '0;
        // Coincident next/prev edges are ambiguous, so both are dropped.
        if (state_q == ST_ACTIVE && !(nxt_rise && prv_rise)) begin
            if (nxt_rise) next_pulse_d = onehot_cur;
            if (prv_rise) prev_pulse_d = onehot_cur;
        end
    end

    assign speaker      = speaker_q;
    assign song_num     = song_q;
    assign next_pulse   = next_pulse_q;
    assign prev_pulse   = prev_pulse_q;
    assign current_mode = cur_q;

endmodule

// File: tb/tb_mode_router.sv
module tb_mode_router;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode_select;
    logic        next_song, prev_song;
    logic [3:0]  speaker_in;
    logic [27:0] display_in;
    logic        speaker;
    logic [6:0]  song_num;
    logic [3:0]  mode_active, next_pulse, prev_pulse;
    logic [1:0]  current_mode;
    logic        switching;

    int checks = 0;
    int failures = 0;
    logic [6:0] exp_song [4] = '{7'h11, 7'h22, 7'h33, 7'h44};

`ifdef MODE_ROUTER_MUTE_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif

    mode_router #(.NUM_MODES(4), .SEL_W(2), .DISP_W(7),
                  .DEBOUNCE_CYCLES(4), .MUTE_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .mode_select(mode_select),
        .next_song(next_song), .prev_song(prev_song),
        .speaker_in(speaker_in), .display_in(display_in),
        .speaker(speaker), .song_num(song_num), .mode_active(mode_active),
        .next_pulse(next_pulse), .prev_pulse(prev_pulse),
        .current_mode(current_mode), .switching(switching)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1; mode_select = 2'd0; next_song = 1'b0; prev_song = 1'b0;
        speaker_in = 4'b0001;
        display_in = {7'h44, 7'h33, 7'h22, 7'h11};
        repeat (3) @(negedge clk);
        checks += 6;
        if (speaker !== 1'b0) begin failures++; $display("FAIL rst_speaker got %b want 0", speaker); end
        if (song_num !== 7'h0) begin failures++; $display("FAIL rst_song got %h want 00", song_num); end
        if (next_pulse !== 4'b0 || prev_pulse !== 4'b0) begin
            failures++; $display("FAIL rst_pulses got %b/%b want 0000/0000", next_pulse, prev_pulse); end
        if (current_mode !== 2'd0) begin failures++; $display("FAIL rst_mode got %0d want 0", current_mode); end
        if (mode_active !== 4'b0001) begin failures++; $display("FAIL rst_active got %b want 0001", mode_active); end
        if (switching !== 1'b0) begin failures++; $display("FAIL rst_switching got %b want 0", switching); end
    endtask

    task automatic test_route();
        reset = 1'b0;
        @(negedge clk);
        checks += 4;
        if (speaker !== 1'b1) begin failures++; $display("FAIL route_speaker got %b want 1", speaker); end
        if (song_num !== 7'h11) begin failures++; $display("FAIL route_song got %h want 11", song_num); end
        if (mode_active !== 4'b0001) begin failures++; $display("FAIL route_active got %b want 0001", mode_active); end
        if (current_mode !== 2'd0) begin failures++; $display("FAIL route_mode got %0d want 0", current_mode); end
        speaker_in = 4'b0000;
        @(negedge clk);
        checks++;
        if (speaker !== 1'b0) begin failures++; $display("FAIL route_latency got %b want 0", speaker); end
        speaker_in = 4'b0101;
        @(negedge clk);
    endtask

    task automatic test_glitch();
        int sw = 0;
        mode_select = 2'd1;
        repeat (3) @(negedge clk);
        mode_select = 2'd0;
        repeat (20) begin
            @(negedge clk);
            if (switching || current_mode != 2'd0) sw++;
        end
        checks += 2;
        if (sw !== 0) begin failures++; $display("FAIL glitch_stable got %0d disturbed cycles want 0", sw); end
        if (mode_active !== 4'b0001) begin failures++; $display("FAIL glitch_active got %b want 0001", mode_active); end
    endtask

    // Debounce accept lands 6 edges after the drive; the FSM reacts one
    // edge later; with the gap the new mode appears 8 cycles after that.
    task automatic switch_to(input logic [1:0] tgt);
        int first_k = 0, first_sw = 0, sw = 0, noisy = 0;
        logic [1:0] start = current_mode;
        logic [1:0] seen = 2'd0;
        mode_select = tgt;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (switching) begin
                sw++;
                if (first_sw == 0) first_sw = k;
                if (speaker !== 1'b0 || song_num !== 7'h0 || mode_active !== 4'b0) noisy++;
            end
            if (current_mode !== start && first_k == 0) begin first_k = k; seen = current_mode; end
        end
        checks += 8;
        if (first_k !== (MUTE ? 15 : 7)) begin failures++; $display("FAIL sw%0d_latency got %0d want %0d", tgt, first_k, MUTE ? 15 : 7); end
        if (seen !== tgt) begin failures++; $display("FAIL sw%0d_mode got %0d want %0d", tgt, seen, tgt); end
        if (first_sw !== (MUTE ? 7 : 0)) begin failures++; $display("FAIL sw%0d_mute_start got %0d want %0d", tgt, first_sw, MUTE ? 7 : 0); end
        if (sw !== (MUTE ? 8 : 0)) begin failures++; $display("FAIL sw%0d_mute_len got %0d want %0d", tgt, sw, MUTE ? 8 : 0); end
        if (noisy !== 0) begin failures++; $display("FAIL sw%0d_mute_silent got %0d noisy want 0", tgt, noisy); end
        if (mode_active !== (4'b0001 << tgt)) begin failures++; $display("FAIL sw%0d_active got %b want %b", tgt, mode_active, 4'b0001 << tgt); end
        if (speaker !== speaker_in[tgt]) begin failures++; $display("FAIL sw%0d_speaker got %b want %b", tgt, speaker, speaker_in[tgt]); end
        if (song_num !== exp_song[tgt]) begin failures++; $display("FAIL sw%0d_song got %h want %h", tgt, song_num, exp_song[tgt]); end
    endtask

    task automatic test_pulses();
        int np = 0, pp = 0, bad = 0;
        next_song = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (next_pulse != 4'b0) begin np++; if (next_pulse !== 4'b0010) bad++; end
            if (prev_pulse != 4'b0) pp++;
        end
        next_song = 1'b0;
        repeat (5) @(negedge clk);
        checks += 3;
        if (np !== 1) begin failures++; $display("FAIL held_next_count got %0d want 1", np); end
        if (bad !== 0) begin failures++; $display("FAIL held_next_target got %0d wrong pulses want 0", bad); end
        if (pp !== 0) begin failures++; $display("FAIL held_next_prev got %0d want 0", pp); end
        np = 0; pp = 0;
        prev_song = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (prev_pulse === 4'b0010) pp++;
            else if (prev_pulse != 4'b0) bad++;
        end
        prev_song = 1'b0;
        repeat (5) @(negedge clk);
        checks += 2;
        if (pp !== 1) begin failures++; $display("FAIL prev_count got %0d want 1", pp); end
        if (bad !== 0) begin failures++; $display("FAIL prev_target got %0d wrong pulses want 0", bad); end
        np = 0; pp = 0;
        next_song = 1'b1; prev_song = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (next_pulse != 4'b0) np++;
            if (prev_pulse != 4'b0) pp++;
        end
        next_song = 1'b0; prev_song = 1'b0;
        repeat (5) @(negedge clk);
        checks += 1;
        if (np + pp !== 0) begin failures++; $display("FAIL both_dropped got %0d/%0d pulses want 0/0", np, pp); end
    endtask

    // Start in mode 0, head for 1, redirect to 2 as the gap begins.
    // Accept of 2 lands at edge 13, reload at edge 14, exit at edge 22.
    task automatic test_retarget();
        int first_k = 0, sw = 0, saw1 = 0;
        logic [1:0] seen = 2'd0;
        mode_select = 2'd1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (switching) sw++;
            if (current_mode === 2'd1) saw1++;
            if (current_mode !== 2'd0 && first_k == 0) begin first_k = k; seen = current_mode; end
            if (k == 7) mode_select = 2'd2;
        end
        checks += 4;
        if (first_k !== 22) begin failures++; $display("FAIL retgt_latency got %0d want 22", first_k); end
        if (seen !== 2'd2) begin failures++; $display("FAIL retgt_mode got %0d want 2", seen); end
        if (sw !== 15) begin failures++; $display("FAIL retgt_mute_len got %0d want 15", sw); end
        if (saw1 !== 0) begin failures++; $display("FAIL retgt_stale got %0d cycles in mode 1 want 0", saw1); end
    endtask

    task automatic test_reset_mid_mute();
        int sw = 0;
        mode_select = 2'd3;
        repeat (11) @(negedge clk);
        checks++;
        if (switching !== 1'b1) begin failures++; $display("FAIL rmid_in_mute got %b want 1", switching); end
        reset = 1'b1; mode_select = 2'd0;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (switching) sw++;
        end
        checks += 3;
        if (current_mode !== 2'd0) begin failures++; $display("FAIL rmid_mode got %0d want 0", current_mode); end
        if (sw !== 0) begin failures++; $display("FAIL rmid_switching got %0d cycles want 0", sw); end
        if (mode_active !== 4'b0001) begin failures++; $display("FAIL rmid_active got %b want 0001", mode_active); end
    endtask

    initial begin
        test_reset();
        test_route();
        test_glitch();
        switch_to(2'd2);
        switch_to(2'd3);
        switch_to(2'd1);
        test_pulses();
        if (MUTE) begin
            switch_to(2'd0);
            test_retarget();
            test_reset_mid_mute();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
